alu_issue_ctrl: RTL and testbench

Instruction-issue stage directly upstream of the team's registered 16-bit ALU. Accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8×16 register file, and drives the ALU operand, opcode and enable inputs. It then captures the registered ALU result and flags one cycle later and writes the result back. It also exposes a debug read port so the register file can be observed (e.g. on Basys 3 LEDs/7-seg).

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the registered 16-bit ALU.
// Accepts one instruction at a time, reads operands from an 8x16 register
// file, drives the ALU for a single cycle and writes the registered result
// and flags back two cycles after acceptance. LDI and illegal opcodes retire
// straight out of ISSUE without touching the ALU.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE; instr is
// ignored whenever instr_ready is low.
module alu_issue_ctrl #(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        flag_zero,
  output logic        flag_carry,
  output logic        flag_overflow,
  output logic        done,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [1:0]  fsm_state
);

  localparam logic [3:0] OP_LDI     = 4'hF;
  localparam logic [3:0] OP_ALU_MAX = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] instr_q;
  logic [15:0] regs [NUM_REGS];

  // Fields of the incoming instruction (used at the accepting edge).
  logic [3:0] in_op;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  // Fields of the latched instruction (used in ISSUE and WB).
  logic [3:0] q_op;
  logic [2:0] q_rd;
  logic [8:0] q_imm;

  assign in_op  = instr[15:12];
  assign in_rs1 = instr[8:6];
  assign in_rs2 = instr[5:3];
  assign q_op   = instr_q[15:12];
  assign q_rd   = instr_q[11:9];
  assign q_imm  = instr_q[8:0];

  assign dbg_data  = regs[dbg_addr];
  assign fsm_state = state;

  // Issue FSM; all outputs registered. Operands are captured on the accepting
  // edge so the ALU sees them during ISSUE; no write can be in flight then,
  // because every writeback completes before IDLE is re-entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      instr_q       <= '0;
      instr_ready   <= 1'b1;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      alu_enable    <= 1'b0;
      flag_zero     <= 1'b1;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done       <= 1'b0;
      illegal    <= 1'b0;
      alu_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= ISSUE;
            if (in_op <= OP_ALU_MAX) begin
              alu_enable <= 1'b1;
              alu_a      <= regs[in_rs1];
              alu_b      <= regs[in_rs2];
              alu_op     <= in_op;
            end else begin
              // LDI and illegal opcodes retire during ISSUE.
              done    <= 1'b1;
              illegal <= (in_op != OP_LDI);
            end
          end
        end
        ISSUE: begin
          if (q_op <= OP_ALU_MAX) begin
            // ALU registers its result at this edge; WB picks it up next.
            done  <= 1'b1;
            state <= WB;
          end else begin
            if (q_op == OP_LDI) begin
              regs[q_rd] <= {7'b0, q_imm};
            end
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        WB: begin
          regs[q_rd]    <= alu_result;
          flag_zero     <= alu_zero;
          flag_carry    <= alu_carry;
          flag_overflow <= alu_overflow;
          instr_ready   <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the result inputs,
// a reference model (register array + flags) predicts every retirement,
// and a negedge monitor compares the DUT against the expected queues.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result = '0;
  logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
  logic        flag_zero, flag_carry, flag_overflow;
  logic        done, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [1:0]  fsm_state;

  alu_issue_ctrl #(.NUM_REGS(8)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_overflow(flag_overflow),
    .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking bookkeeping ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural ALU (registered) ----------------
  function automatic logic [18:0] alu_ref(input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h1: begin r = a - b; c = (a < b);
                  v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: begin r = a << 1; c = a[15]; end
      4'h7: begin r = a >> 1; c = a[0]; end
      4'h8: r = (a == b) ? 16'd1 : 16'd0;
      4'h9: r = (a < b) ? 16'd1 : 16'd0;
      4'hA: r = (a <= b) ? 16'd1 : 16'd0;
      4'hB: begin p = {16'b0, a} * {16'b0, b}; r = p[15:0]; c = |p[31:16]; end
      default: r = '0;
    endcase
    return {r, (r == 16'd0), c, v};
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {alu_result, alu_zero, alu_carry, alu_overflow} <= alu_ref(alu_op, alu_a, alu_b);
  end

  // ---------------- reference model and expected queues ----------------
  typedef struct packed {
    logic        ill;
    logic        alu;
    logic [2:0]  rd;
    logic [15:0] val;
    logic        z, c, v;
    logic [31:0] acc;
  } ret_t;

  typedef struct packed {
    logic [15:0] a, b;
    logic [3:0]  op;
    logic [31:0] acc;
  } iss_t;

  ret_t        exp_q[$];
  iss_t        iss_q[$];
  logic [15:0] m_regs [8];
  logic        m_z = 1'b1, m_c = 1'b0, m_v = 1'b0;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_z = 1'b1; m_c = 1'b0; m_v = 1'b0;
  endtask

  // Called at the edge where an instruction is accepted.
  task automatic model_accept(input logic [15:0] ins);
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [18:0] r;
    ret_t e;
    iss_t s;
    op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
    e.acc = 32'(cyc); e.rd = rd; e.ill = 1'b0; e.alu = 1'b0;
    if (op <= 4'hB) begin
      r = alu_ref(op, m_regs[rs1], m_regs[rs2]);
      s.a = m_regs[rs1]; s.b = m_regs[rs2]; s.op = op; s.acc = 32'(cyc);
      iss_q.push_back(s);
      m_regs[rd] = r[18:3];
      {m_z, m_c, m_v} = r[2:0];
      e.alu = 1'b1;
    end else if (op == 4'hF) begin
      m_regs[rd] = {7'b0, ins[8:0]};
    end else begin
      e.ill = 1'b1;
    end
    e.val = m_regs[rd];
    e.z = m_z; e.c = m_c; e.v = m_v;
    exp_q.push_back(e);
  endtask

  // ---------------- debug-port mux ----------------
  bit         sweep_mode = 1'b0;
  logic [2:0] sweep_addr = '0;
  logic [2:0] mon_addr = '0;
  assign dbg_addr = sweep_mode ? sweep_addr : mon_addr;

  // ---------------- monitor ----------------
  bit   pend = 1'b0;
  ret_t pend_e;

  always @(negedge clk) begin
    ret_t e;
    iss_t s;
    cyc++;
    if (mon_en) begin
      if (pend) begin
        chk(dbg_data == pend_e.val, "wb_value", 32'(dbg_data), 32'(pend_e.val));
        chk({flag_zero, flag_carry, flag_overflow} == {pend_e.z, pend_e.c, pend_e.v},
            "flags", 32'({flag_zero, flag_carry, flag_overflow}),
            32'({pend_e.z, pend_e.c, pend_e.v}));
        pend = 1'b0;
      end
      chk(instr_ready == (exp_q.size() == 0), "instr_ready",
          32'(instr_ready), 32'(exp_q.size() == 0));
      if (alu_enable) begin
        if (iss_q.size() == 0) chk(1'b0, "unexpected_alu_enable", 32'(1), 32'(0));
        else begin
          s = iss_q.pop_front();
          chk(32'(cyc) == s.acc + 1, "alu_enable_cycle", 32'(cyc), s.acc + 1);
          chk(alu_a == s.a, "alu_a", 32'(alu_a), 32'(s.a));
          chk(alu_b == s.b, "alu_b", 32'(alu_b), 32'(s.b));
          chk(alu_op == s.op, "alu_op", 32'(alu_op), 32'(s.op));
        end
      end else if (iss_q.size() > 0 && 32'(cyc) > iss_q[0].acc) begin
        chk(1'b0, "missing_alu_enable", 32'(0), 32'(1));
        void'(iss_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_done", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk(32'(cyc) == e.acc + (e.alu ? 2 : 1), "done_cycle", 32'(cyc),
              e.acc + (e.alu ? 2 : 1));
          chk(illegal == e.ill, "illegal", 32'(illegal), 32'(e.ill));
          mon_addr = e.rd;
          pend_e = e;
          pend = 1'b1;
        end
      end else if (exp_q.size() > 0 && 32'(cyc) > exp_q[0].acc + 2) begin
        chk(1'b0, "missing_done", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      if (illegal && !done) chk(1'b0, "illegal_without_done", 32'(1), 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  // Present ins; hold==0 keeps it until one acceptance, otherwise for hold cycles.
  task automatic issue(input logic [15:0] ins, input int hold);
    int  n;
    bit  acc;
    logic r;
    n = 0; acc = 1'b0;
    @(posedge clk); #1;
    instr = ins;
    instr_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = instr_ready;
      @(posedge clk);
      if (r) begin model_accept(ins); acc = 1'b1; end
      n++;
      #1;
      if ((hold == 0) ? acc : (n >= hold)) break;
      if (n > 50) begin chk(1'b0, "accept_timeout", 32'(n), 32'(50)); break; end
    end
    instr_valid = 1'b0;
    instr = 16'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reg(input logic [2:0] a, input logic [15:0] exp, input string name);
    sweep_mode = 1'b1;
    sweep_addr = a;
    @(negedge clk);
    chk(dbg_data == exp, name, 32'(dbg_data), 32'(exp));
    sweep_mode = 1'b0;
  endtask

  task automatic check_flags(input logic z, input logic c, input logic v, input string name);
    chk({flag_zero, flag_carry, flag_overflow} == {z, c, v}, name,
        32'({flag_zero, flag_carry, flag_overflow}), 32'({z, c, v}));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "reset_reg");
    check_flags(1'b1, 1'b0, 1'b0, "reset_flags");
    chk(instr_ready == 1'b1, "reset_ready", 32'(instr_ready), 32'(1));
    chk({alu_enable, done, illegal} == 3'b000, "reset_pulses",
        32'({alu_enable, done, illegal}), 32'(0));
    chk({alu_a, alu_b, alu_op} == 36'd0, "reset_alu_outs", 32'({alu_a, alu_op}), 32'(0));
    mon_en = 1'b1;

    // LDI r1,0x1FF ; LDI r2,0x001
    issue({4'hF, 3'd1, 9'h1FF}, 0);
    wait_idle();
    issue({4'hF, 3'd2, 9'h001}, 0);
    wait_idle();
    check_reg(3'd1, 16'h01FF, "ldi_r1");
    check_reg(3'd2, 16'h0001, "ldi_r2");

    // ADD r3,r1,r2
    issue(enc(4'h0, 3'd3, 3'd1, 3'd2), 0);
    wait_idle();
    check_reg(3'd3, 16'h0200, "add_r3");
    check_flags(1'b0, 1'b0, 1'b0, "add_flags");

    // SUB r4,r2,r1 ; SUB r5,r1,r1
    issue(enc(4'h1, 3'd4, 3'd2, 3'd1), 0);
    wait_idle();
    check_reg(3'd4, 16'hFE02, "sub_r4");
    check_flags(1'b0, 1'b1, 1'b0, "sub_r4_flags");
    issue(enc(4'h1, 3'd5, 3'd1, 3'd1), 0);
    wait_idle();
    check_reg(3'd5, 16'h0000, "sub_r5");
    check_flags(1'b1, 1'b0, 1'b0, "sub_r5_flags");

    // Illegal opcode 0xD, valid held for 5 cycles, targets r1
    issue(enc(4'hD, 3'd1, 3'd2, 3'd3), 5);
    wait_idle();
    check_reg(3'd1, 16'h01FF, "illegal_no_write");
    check_flags(1'b1, 1'b0, 1'b0, "illegal_flags");

    // Reset during WB of ADD r6,r1,r2
    mon_en = 1'b0;
    issue(enc(4'h0, 3'd6, 3'd1, 3'd2), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(instr_ready == 1'b1, "rst_mid_ready", 32'(instr_ready), 32'(1));
    chk(fsm_state == 2'd0, "rst_mid_state", 32'(fsm_state), 32'(0));
    chk(done == 1'b0, "rst_mid_done", 32'(done), 32'(0));
    chk(alu_enable == 1'b0, "rst_mid_enable", 32'(alu_enable), 32'(0));
    check_flags(1'b1, 1'b0, 1'b0, "rst_mid_flags");
    check_reg(3'd6, 16'h0000, "rst_mid_r6");
    check_reg(3'd1, 16'h0000, "rst_mid_r1_cleared");
    exp_q.delete();
    iss_q.delete();
    pend = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Randomized traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      issue({4'($urandom_range(0, 15)), 12'($urandom)}, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    for (int i = 0; i < 8; i++) check_reg(3'(i), m_regs[i], "final_reg");
    check_flags(m_z, m_c, m_v, "final_flags");
    chk(iss_q.size() == 0, "issue_queue_empty", 32'(iss_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
